// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter driving the select input of a 2-to-4 one-hot decoder.
// Latency: a request seen in IDLE is granted after the next edge; a release drops gnt_valid after the next edge.
// Backpressure: the owner keeps the grant until done, request drop or (with RR_ARBITER4_TIMEOUT_EN) hold timeout.
module rr_arbiter4 #(
    parameter int CNT_W    = 4,
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ptr;
    logic [1:0]       pick;
    logic             found;
    logic [CNT_W-1:0] hold_cnt;
    logic             tmo_hit;
    logic             release_evt;

    // Round-robin search: first set request at or after ptr, wrapping 3->0.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr + 2'(i)]) begin
                found = 1'b1;
                pick  = ptr + 2'(i);
            end
        end
    end

`ifdef RR_ARBITER4_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    // Forced revocation only when the owner would otherwise keep the grant.
    always_comb begin
        tmo_hit = (state == GRANT) && (hold_cnt == HOLD_LIM) && !done && req[gnt_idx];
    end

    // One-cycle timeout pulse, coincident with the first cycle without a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= tmo_hit;
        end
    end
`else
    // No hold limit in this build; the parameter is kept only for a uniform interface.
    logic [CNT_W-1:0] unused_hold_max;
    assign unused_hold_max = CNT_W'(HOLD_MAX);
    assign tmo_hit         = 1'b0;
    assign timeout         = 1'b0;
`endif

    // Any one of these ends the current grant; done and a dropped request together still release once.
    always_comb begin
        release_evt = done || !req[gnt_idx] || tmo_hit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a dead IDLE cycle always separates two grants.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)       state_nxt = GRANT;
            GRANT:   if (release_evt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the grant is valid exactly while in GRANT.
    always_comb begin
        gnt_valid = (state == GRANT);
    end

    // Grant index, pointer and hold counter; gnt_idx only moves on IDLE->GRANT so the decoder stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_idx  <= 2'b00;
            ptr      <= 2'b00;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt_idx  <= pick;
                        hold_cnt <= CNT_ONE;
                    end
                end
                GRANT: begin
                    if (release_evt) begin
                        ptr <= gnt_idx + 2'd1;
                    end else if (hold_cnt != CNT_SAT) begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
